io_port_serializer: RTL and testbench
=====================================

IO_PORT_SERIALIZER -- requirements
Module: io_port_serializer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - PORTBYTEWIDTH, 8: port word width in bytes, even and ≥2.
  - TIMEOUTCYCLES, 255: load watchdog limit in cycles.
REQ-002 Ports (name direction width meaning), one per line:
  - clk  in  1  single clock.
  - async_rst_n  in  1  reset, asynchronous, active-low.
  - clk_en  in  1  global advance enable.
  - CmdACK  in  1  command valid from upstream IO command interface.
  - CmdREQ  out  1  command ready.
  - LoadEnIn  in  1  load request.
  - StoreEnIn  in  1  store request.
  - CmdData  in  PORTBYTEWIDTH*8  store word.
  - ByteOutValid  out  1  store byte valid.
  - ByteOutReady  in  1  store byte ready.
  - ByteOut  out  8  store byte.
  - ByteOutLast  out  1  final byte of word.
  - ReadReqValid  out  1  device read request.
  - ReadReqReady  in  1  read request accept.
  - ByteInValid  in  1  load byte valid.
  - ByteInReady  out  1  load byte ready.
  - ByteIn  in  8  load byte.
  - RespValid  out  1  load response valid.
  - RespReady  in  1  response accept.
  - RespData  out  PORTBYTEWIDTH*8  assembled load word.
  - RespError  out  1  load timed out.

Function
REQ-003 A transfer completes only on a cycle with valid, ready and clk_en all high. No state, counter or register changes while clk_en is low.
REQ-004 FSM states: IDLE, STORE, LOAD_REQ, LOAD_COLLECT, RESP.
REQ-005 CmdREQ is high only in IDLE.
REQ-006 Command acceptance captures CmdData, LoadEnIn and StoreEnIn, and clears the byte counter.
REQ-007 Next state on acceptance:
  - StoreEnIn=1 → STORE.
  - LoadEnIn=1, StoreEnIn=0 → LOAD_REQ.
  - both 0 → stay in IDLE; the command is dropped with no bus activity.
REQ-008 STORE behaviour:
  - ByteOutValid is high.
  - ByteOut is byte[counter] of the captured word, byte 0 = bits 7:0, LSB first.
  - ByteOutLast is high when counter = PORTBYTEWIDTH-1.
  - Each transfer increments the counter.
REQ-009 Last store byte transfer → counter clears; next state is LOAD_REQ if the captured LoadEn=1 (exchange), otherwise IDLE.
REQ-010 LOAD_REQ: ReadReqValid is high. On transfer → LOAD_COLLECT, counter cleared.
REQ-011 LOAD_COLLECT: ByteInReady is high. Each transfer writes ByteIn into byte[counter] of the response register and increments the counter. The last byte → RESP.
REQ-012 RESP behaviour:
  - RespValid is high.
  - RespData and RespError are held stable until transfer.
  - On transfer → IDLE.
REQ-013 Outside their states, ByteOutValid, ReadReqValid, ByteInReady and RespValid are 0.
REQ-014 Latency, with all partners ready:
  - store: 1 cycle accept + PORTBYTEWIDTH cycles.
  - load: 1 + 1 + PORTBYTEWIDTH cycles, then RespValid in the next cycle.
REQ-015 Counter width is $clog2(PORTBYTEWIDTH). The counter never wraps; the last-byte compare ends each phase.
REQ-016 Back-to-back: CmdREQ rises in the cycle after return to IDLE; IDLE is not bypassed.

Reset
REQ-017 async_rst_n low immediately forces:
  - state IDLE, counter 0, timeout counter 0.
  - captured command and response register 0.
  - all valid/ready outputs 0, RespError 0.
REQ-018 Reset mid-transfer aborts the transfer silently; no partial response is emitted after release.
REQ-019 After release, CmdREQ is high in the first clock cycle.

Configuration
REQ-020 Macro IO_SERIALIZER_TIMEOUT_EN controls the load watchdog.
REQ-021 When defined:
  - A counter runs in LOAD_COLLECT, clears on each byte transfer, and advances only with clk_en.
  - Reaching TIMEOUTCYCLES forces RESP with RespError=1 and unreceived bytes zero.
REQ-022 When undefined: no watchdog logic, RespError is tied 0, and LOAD_COLLECT waits indefinitely.

Structure
REQ-023 Shared package io_pkg holds:
  - the state enum typedef io_ser_state_t.
  - the byte width constant IO_BYTE_BITS = 8.
REQ-024 One sub-module, io_byte_counter, provides the load/clear/increment/last-flag logic and is instantiated once.

Verification
REQ-025 Store 0x8877665544332211, PORTBYTEWIDTH=8, ByteOutReady always 1 → bytes 0x11..0x88 on consecutive cycles, ByteOutLast only with 0x88, CmdREQ high again 9 cycles after accept.
REQ-026 Load with ByteIn 0xA0..0xA7, ByteInReady stalls inserted → RespData=0xA7A6A5A4A3A2A1A0, RespError=0, RespData held under RespReady=0 for 5 cycles.
REQ-027 LoadEn=StoreEn=1, data 0x0102030405060708 → 8 store bytes, then a ReadReqValid pulse, then 8-byte collect, then one response.
REQ-028 Accept with LoadEn=StoreEn=0 → no bus valids asserted, CmdREQ stays high; clk_en held low for 4 cycles mid-store → ByteOut frozen, no byte skipped.
REQ-029 With IO_SERIALIZER_TIMEOUT_EN, TIMEOUTCYCLES=10: 3 bytes 0x11,0x22,0x33 then silence → RESP after 10 idle cycles, RespData=0x0000000000332211, RespError=1.
REQ-030 async_rst_n pulsed low after 4 store bytes → outputs 0 immediately, IDLE with CmdREQ=1 after release, no further ByteOutValid.

Source files
------------

// File: rtl/io_pkg.sv
// Purpose: shared state encoding and byte-width constant for the IO port serializer slice.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package io_pkg;

    localparam int IO_BYTE_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD_REQ,
        LOAD_COLLECT,
        RESP
    } io_ser_state_t;

endpackage

// File: rtl/io_port_serializer_if.sv
// Purpose: command, byte-stream and response handshake bundle of the IO port serializer.
// Latency: none (wires only).
// Backpressure: every channel is valid/ready; the serializer owns the slave modport.
interface io_port_serializer_if
    import io_pkg::*;
#(
    parameter int PORTBYTEWIDTH = 8
);
    logic                                  CmdACK;
    logic                                  CmdREQ;
    logic                                  LoadEnIn;
    logic                                  StoreEnIn;
    logic [PORTBYTEWIDTH*IO_BYTE_BITS-1:0] CmdData;
    logic                                  ByteOutValid;
    logic                                  ByteOutReady;
    logic [IO_BYTE_BITS-1:0]               ByteOut;
    logic                                  ByteOutLast;
    logic                                  ReadReqValid;
    logic                                  ReadReqReady;
    logic                                  ByteInValid;
    logic                                  ByteInReady;
    logic [IO_BYTE_BITS-1:0]               ByteIn;
    logic                                  RespValid;
    logic                                  RespReady;
    logic [PORTBYTEWIDTH*IO_BYTE_BITS-1:0] RespData;
    logic                                  RespError;

    modport master (
        output CmdACK, LoadEnIn, StoreEnIn, CmdData, ByteOutReady, ReadReqReady,
               ByteInValid, ByteIn, RespReady,
        input  CmdREQ, ByteOutValid, ByteOut, ByteOutLast, ReadReqValid, ByteInReady,
               RespValid, RespData, RespError
    );

    modport slave (
        input  CmdACK, LoadEnIn, StoreEnIn, CmdData, ByteOutReady, ReadReqReady,
               ByteInValid, ByteIn, RespReady,
        output CmdREQ, ByteOutValid, ByteOut, ByteOutLast, ReadReqValid, ByteInReady,
               RespValid, RespData, RespError
    );

endinterface

// File: rtl/io_byte_counter.sv
// Purpose: byte index within a port word with clear, increment and last-byte flag.
// Latency: count updates one clock after clr/inc; last is combinational from count.
// Backpressure: none; the caller qualifies clr/inc with its own handshakes.
module io_byte_counter #(
    parameter int NUMBYTES = 8,
    parameter int CNTW     = $clog2(NUMBYTES)
) (
    input  logic            clk,
    input  logic            async_rst_n,
    input  logic            clr,
    input  logic            inc,
    output logic [CNTW-1:0] count,
    output logic            last
);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CNTW'(NUMBYTES - 1));

endmodule

// File: rtl/io_port_serializer.sv
// Purpose: serializes store words to bytes and assembles load bytes into a word; IO_SERIALIZER_TIMEOUT_EN adds a load watchdog.
// Latency: store 1 + PORTBYTEWIDTH cycles; load 1 + 1 + PORTBYTEWIDTH cycles then response.
// Backpressure: every channel stalls on its ready; nothing advances while clk_en is low.
module io_port_serializer
    import io_pkg::*;
#(
    parameter int PORTBYTEWIDTH = 8,
    parameter int TIMEOUTCYCLES = 255
) (
    input  logic                 clk,
    input  logic                 async_rst_n,
    input  logic                 clk_en,
    io_port_serializer_if.slave  bus
);

    localparam int CNTW = $clog2(PORTBYTEWIDTH);

    if (PORTBYTEWIDTH < 2 || (PORTBYTEWIDTH % 2) != 0 || TIMEOUTCYCLES < 1) begin : gBadParam
        $error("io_port_serializer: PORTBYTEWIDTH must be even and >= 2, TIMEOUTCYCLES >= 1");
    end

    io_ser_state_t                                   state;
    logic                                            cmdReq;
    logic                                            byteOutVld;
    logic                                            readReqVld;
    logic                                            byteInRdy;
    logic                                            respVld;
    logic                                            loadEnQ;
    logic [PORTBYTEWIDTH-1:0][IO_BYTE_BITS-1:0]      cmdWord;
    logic [PORTBYTEWIDTH-1:0][IO_BYTE_BITS-1:0]      respWord;
    logic [CNTW-1:0]                                 cnt;
    logic                                            cntLast;
    logic                                            cntClr;
    logic                                            cntInc;
    logic                                            accept;
    logic                                            storeXfer;
    logic                                            readXfer;
    logic                                            byteInXfer;

    assign accept     = clk_en & cmdReq     & bus.CmdACK;
    assign storeXfer  = clk_en & byteOutVld & bus.ByteOutReady;
    assign readXfer   = clk_en & readReqVld & bus.ReadReqReady;
    assign byteInXfer = clk_en & byteInRdy  & bus.ByteInValid;

    // The last-byte compare ends each phase, so the counter is cleared instead of wrapping.
    assign cntClr = accept | readXfer | ((storeXfer | byteInXfer) & cntLast);
    assign cntInc = (storeXfer | byteInXfer) & ~cntLast;

    io_byte_counter #(
        .NUMBYTES (PORTBYTEWIDTH),
        .CNTW     (CNTW)
    ) uByteCounter (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .clr         (cntClr),
        .inc         (cntInc),
        .count       (cnt),
        .last        (cntLast)
    );

`ifdef IO_SERIALIZER_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUTCYCLES + 1);
    logic [TOW-1:0] toCnt;
    logic           respErr;
`endif

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state      <= IDLE;
            cmdReq     <= 1'b0;
            byteOutVld <= 1'b0;
            readReqVld <= 1'b0;
            byteInRdy  <= 1'b0;
            respVld    <= 1'b0;
            loadEnQ    <= 1'b0;
            cmdWord    <= '0;
            respWord   <= '0;
`ifdef IO_SERIALIZER_TIMEOUT_EN
            toCnt      <= '0;
            respErr    <= 1'b0;
`endif
        end else if (clk_en) begin
            unique case (state)
                IDLE: begin
                    // CmdREQ only rises a cycle after entering IDLE; a dropped command keeps it high.
                    if (cmdReq && bus.CmdACK) begin
                        cmdWord <= bus.CmdData;
                        loadEnQ <= bus.LoadEnIn;
                        if (bus.StoreEnIn) begin
                            state      <= STORE;
                            cmdReq     <= 1'b0;
                            byteOutVld <= 1'b1;
                        end else if (bus.LoadEnIn) begin
                            state      <= LOAD_REQ;
                            cmdReq     <= 1'b0;
                            readReqVld <= 1'b1;
                        end
                    end else begin
                        cmdReq <= 1'b1;
                    end
                end
                STORE: begin
                    if (bus.ByteOutReady && cntLast) begin
                        byteOutVld <= 1'b0;
                        if (loadEnQ) begin
                            state      <= LOAD_REQ;
                            readReqVld <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                LOAD_REQ: begin
                    if (bus.ReadReqReady) begin
                        state      <= LOAD_COLLECT;
                        readReqVld <= 1'b0;
                        byteInRdy  <= 1'b1;
                        respWord   <= '0;
`ifdef IO_SERIALIZER_TIMEOUT_EN
                        toCnt      <= '0;
                        respErr    <= 1'b0;
`endif
                    end
                end
                LOAD_COLLECT: begin
                    if (bus.ByteInValid) begin
                        respWord[cnt] <= bus.ByteIn;
`ifdef IO_SERIALIZER_TIMEOUT_EN
                        toCnt         <= '0;
`endif
                        if (cntLast) begin
                            state     <= RESP;
                            byteInRdy <= 1'b0;
                            respVld   <= 1'b1;
                        end
                    end
`ifdef IO_SERIALIZER_TIMEOUT_EN
                    else if (toCnt == TOW'(TIMEOUTCYCLES - 1)) begin
                        // Unreceived bytes stay zero from the clear on entry.
                        state     <= RESP;
                        byteInRdy <= 1'b0;
                        respVld   <= 1'b1;
                        respErr   <= 1'b1;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.RespReady) begin
                        state   <= IDLE;
                        respVld <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CmdREQ       = cmdReq;
    assign bus.ByteOutValid = byteOutVld;
    assign bus.ByteOut      = cmdWord[cnt];
    assign bus.ByteOutLast  = byteOutVld & cntLast;
    assign bus.ReadReqValid = readReqVld;
    assign bus.ByteInReady  = byteInRdy;
    assign bus.RespValid    = respVld;
    assign bus.RespData     = respWord;
`ifdef IO_SERIALIZER_TIMEOUT_EN
    assign bus.RespError    = respErr;
`else
    assign bus.RespError    = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_serializer.sv
// Directed bench for io_port_serializer: store, load with stalls, exchange, dropped command,
// clk_en freeze, load watchdog (or indefinite wait without IO_SERIALIZER_TIMEOUT_EN), mid-store reset.
module tb_io_port_serializer;

    logic clk;
    logic async_rst_n;
    logic clk_en;
    int   nCmp;
    int   nErr;

    io_port_serializer_if #(.PORTBYTEWIDTH(8)) bus ();

    io_port_serializer #(
        .PORTBYTEWIDTH (8),
        .TIMEOUTCYCLES (10)
    ) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .clk_en      (clk_en),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCmp++;
        assert (observed === expected) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [4:0] valids();
        return {bus.ByteOutValid, bus.ReadReqValid, bus.ByteInReady, bus.RespValid, bus.RespError};
    endfunction

    task automatic issue(input logic ld, input logic st, input logic [63:0] d);
        bus.CmdACK    = 1'b1;
        bus.LoadEnIn  = ld;
        bus.StoreEnIn = st;
        bus.CmdData   = d;
        tick();
        bus.CmdACK    = 1'b0;
        bus.LoadEnIn  = 1'b0;
        bus.StoreEnIn = 1'b0;
    endtask

    initial begin
        logic [63:0] word;
        nCmp = 0;
        nErr = 0;
        async_rst_n      = 1'b0;
        clk_en           = 1'b1;
        bus.CmdACK       = 1'b0;
        bus.LoadEnIn     = 1'b0;
        bus.StoreEnIn    = 1'b0;
        bus.CmdData      = '0;
        bus.ByteOutReady = 1'b0;
        bus.ReadReqReady = 1'b0;
        bus.ByteInValid  = 1'b0;
        bus.ByteIn       = '0;
        bus.RespReady    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cmdreq", 64'(bus.CmdREQ), 64'd0);
        check("rst_valids", 64'(valids()), 64'd0);
        check("rst_respdata", bus.RespData, 64'd0);
        async_rst_n = 1'b1;
        tick();
        check("rel_cmdreq", 64'(bus.CmdREQ), 64'd1);

        // Plain store, sink always ready
        bus.ByteOutReady = 1'b1;
        issue(1'b0, 1'b1, 64'h8877665544332211);
        for (int k = 0; k < 8; k++) begin
            check("st_vld", 64'(bus.ByteOutValid), 64'd1);
            check("st_byte", 64'(bus.ByteOut), 64'(8'h11 * (k + 1)));
            check("st_last", 64'(bus.ByteOutLast), 64'(k == 7));
            check("st_cmdreq_low", 64'(bus.CmdREQ), 64'd0);
            tick();
        end
        check("st_done_vld", 64'(bus.ByteOutValid), 64'd0);
        check("st_cmdreq_8", 64'(bus.CmdREQ), 64'd0);
        tick();
        check("st_cmdreq_9", 64'(bus.CmdREQ), 64'd1);

        // Load with read-request stall and byte stalls, response held
        issue(1'b1, 1'b0, 64'h0);
        check("ld_rreq", 64'(bus.ReadReqValid), 64'd1);
        check("ld_cmdreq_low", 64'(bus.CmdREQ), 64'd0);
        tick();
        check("ld_rreq_held", 64'(bus.ReadReqValid), 64'd1);
        bus.ReadReqReady = 1'b1;
        tick();
        bus.ReadReqReady = 1'b0;
        check("ld_rreq_done", 64'(bus.ReadReqValid), 64'd0);
        check("ld_inrdy", 64'(bus.ByteInReady), 64'd1);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 1) begin
                bus.ByteInValid = 1'b0;
                tick();
                check("ld_stall_rdy", 64'(bus.ByteInReady), 64'd1);
            end
            bus.ByteInValid = 1'b1;
            bus.ByteIn      = 8'(8'hA0 + k);
            tick();
        end
        bus.ByteInValid = 1'b0;
        check("ld_inrdy_done", 64'(bus.ByteInReady), 64'd0);
        for (int k = 0; k < 5; k++) begin
            check("ld_resp_vld", 64'(bus.RespValid), 64'd1);
            check("ld_resp_data", bus.RespData, 64'hA7A6A5A4A3A2A1A0);
            check("ld_resp_err", 64'(bus.RespError), 64'd0);
            tick();
        end
        bus.RespReady = 1'b1;
        tick();
        bus.RespReady = 1'b0;
        check("ld_resp_gone", 64'(bus.RespValid), 64'd0);
        tick();
        check("ld_cmdreq_back", 64'(bus.CmdREQ), 64'd1);

        // Exchange: store then load
        bus.ReadReqReady = 1'b1;
        issue(1'b1, 1'b1, 64'h0102030405060708);
        for (int k = 0; k < 8; k++) begin
            check("ex_byte", 64'(bus.ByteOut), 64'(8'h08 - k));
            check("ex_rreq_low", 64'(bus.ReadReqValid), 64'd0);
            tick();
        end
        check("ex_st_done", 64'(bus.ByteOutValid), 64'd0);
        check("ex_rreq", 64'(bus.ReadReqValid), 64'd1);
        tick();
        check("ex_rreq_pulse", 64'(bus.ReadReqValid), 64'd0);
        check("ex_inrdy", 64'(bus.ByteInReady), 64'd1);
        for (int k = 0; k < 8; k++) begin
            bus.ByteInValid = 1'b1;
            bus.ByteIn      = 8'(8'hB0 + k);
            tick();
        end
        bus.ByteInValid = 1'b0;
        check("ex_resp_vld", 64'(bus.RespValid), 64'd1);
        check("ex_resp_data", bus.RespData, 64'hB7B6B5B4B3B2B1B0);
        bus.RespReady = 1'b1;
        tick();
        bus.RespReady = 1'b0;
        check("ex_one_resp", 64'(valids()), 64'd0);
        tick();
        check("ex_cmdreq_back", 64'(bus.CmdREQ), 64'd1);

        // Dropped command
        issue(1'b0, 1'b0, 64'hDEADBEEFDEADBEEF);
        check("drop_cmdreq", 64'(bus.CmdREQ), 64'd1);
        check("drop_valids", 64'(valids()), 64'd0);
        tick();
        check("drop_cmdreq2", 64'(bus.CmdREQ), 64'd1);
        check("drop_valids2", 64'(valids()), 64'd0);

        // clk_en low for 4 cycles mid-store
        issue(1'b0, 1'b1, 64'h8877665544332211);
        tick();
        tick();
        clk_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ce_frozen_byte", 64'(bus.ByteOut), 64'h33);
            check("ce_frozen_vld", 64'(bus.ByteOutValid), 64'd1);
        end
        clk_en = 1'b1;
        for (int k = 2; k < 8; k++) begin
            check("ce_byte", 64'(bus.ByteOut), 64'(8'h11 * (k + 1)));
            check("ce_last", 64'(bus.ByteOutLast), 64'(k == 7));
            tick();
        end
        check("ce_done", 64'(bus.ByteOutValid), 64'd0);
        tick();
        check("ce_cmdreq", 64'(bus.CmdREQ), 64'd1);

        // Partial load: watchdog fires, or collection waits indefinitely
        issue(1'b1, 1'b0, 64'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.ByteInValid = 1'b1;
            bus.ByteIn      = 8'(8'h11 * (k + 1));
            tick();
        end
        bus.ByteInValid = 1'b0;
`ifdef IO_SERIALIZER_TIMEOUT_EN
        for (int k = 0; k < 9; k++) tick();
        check("to_not_yet", 64'(bus.RespValid), 64'd0);
        tick();
        check("to_resp_vld", 64'(bus.RespValid), 64'd1);
        check("to_resp_data", bus.RespData, 64'h0000000000332211);
        check("to_resp_err", 64'(bus.RespError), 64'd1);
        check("to_inrdy", 64'(bus.ByteInReady), 64'd0);
`else
        for (int k = 0; k < 20; k++) tick();
        check("wait_no_resp", 64'(bus.RespValid), 64'd0);
        check("wait_inrdy", 64'(bus.ByteInReady), 64'd1);
        for (int k = 3; k < 8; k++) begin
            bus.ByteInValid = 1'b1;
            bus.ByteIn      = 8'(8'h11 * (k + 1));
            tick();
        end
        bus.ByteInValid = 1'b0;
        check("wait_resp_vld", 64'(bus.RespValid), 64'd1);
        check("wait_resp_data", bus.RespData, 64'h8877665544332211);
        check("wait_resp_err", 64'(bus.RespError), 64'd0);
`endif
        bus.RespReady = 1'b1;
        tick();
        bus.RespReady = 1'b0;
        tick();
        check("pl_cmdreq", 64'(bus.CmdREQ), 64'd1);

        // Reset after 4 store bytes
        word = 64'h8877665544332211;
        issue(1'b0, 1'b1, word);
        for (int k = 0; k < 4; k++) tick();
        check("rs_pre_byte", 64'(bus.ByteOut), 64'h55);
        async_rst_n = 1'b0;
        #2;
        check("rs_now_valids", 64'(valids()), 64'd0);
        check("rs_now_cmdreq", 64'(bus.CmdREQ), 64'd0);
        tick();
        async_rst_n = 1'b1;
        tick();
        check("rs_rel_cmdreq", 64'(bus.CmdREQ), 64'd1);
        for (int k = 0; k < 6; k++) begin
            check("rs_quiet", 64'(valids()), 64'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
